// File: rtl/run_pattern_gen.sv
// rtl/run_pattern_gen.sv - run-length serial stimulus generator with command FIFO
// Optional macro RUN_PATTERN_GEN_EXPECT_Z_EN adds the expected four-equal-bit detector output exp_z.
module run_pattern_gen #(
  parameter int LEN_W = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_bit,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             w,
  output logic             w_valid,
  output logic             busy,
  output logic             done,
  output logic             exp_z
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]   PTR_ONE  = (AW)'(1);
  localparam logic [LEN_W:0]  REM_ONE  = (LEN_W+1)'(1);
  localparam logic [LEN_W:0]  REM_MAX  = {1'b1, {LEN_W{1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;

  logic [LEN_W:0]   mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  state_t           state;
  logic             cur_bit;
  logic [LEN_W:0]   rem;
  logic             push;
  logic             pop;
  logic             head_bit;
  logic [LEN_W-1:0] head_len;
  logic [LEN_W:0]   head_rem;

  // Ready comes from the registered count only, so a full FIFO never accepts on a pop cycle.
  assign cmd_ready = (count < FULL_CNT);
  assign push      = cmd_valid & cmd_ready;
  // Pop to start a run from IDLE, or to chain the next run onto the last bit of the current one.
  assign pop       = en & (count != '0) & ((state == IDLE) | (rem == REM_ONE));
  assign head_bit  = mem[rd_ptr][LEN_W];
  assign head_len  = mem[rd_ptr][LEN_W-1:0];
  assign head_rem  = (head_len == '0) ? REM_MAX : {1'b0, head_len};
  assign busy      = (state == RUN) | (count != '0);

  // Command storage; contents need no reset since count guards every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_bit, cmd_len};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Serializer FSM: emits one bit per enabled cycle and chains queued runs without bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cur_bit <= 1'b0;
      rem     <= '0;
      w       <= 1'b0;
      w_valid <= 1'b0;
      done    <= 1'b0;
    end else begin
      w_valid <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            cur_bit <= head_bit;
            rem     <= head_rem;
            state   <= RUN;
          end
        end
        RUN: begin
          if (en) begin
            w       <= cur_bit;
            w_valid <= 1'b1;
            if (rem == REM_ONE) begin
              if (pop) begin
                cur_bit <= head_bit;
                rem     <= head_rem;
              end else begin
                rem   <= '0;
                state <= IDLE;
                done  <= 1'b1;
              end
            end else begin
              rem <= rem - REM_ONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RUN_PATTERN_GEN_EXPECT_Z_EN
  logic [4:0] hist;
  logic [2:0] fill;
  logic       emit;

  assign emit = en & (state == RUN);

  // Expected detector output, computed from the history before this bit is shifted in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist  <= '0;
      fill  <= '0;
      exp_z <= 1'b0;
    end else if (emit) begin
      exp_z <= ((fill >= 3'd4) && (hist[3:0] == 4'b0000)) ||
               ((fill >= 3'd3) && (hist[2:0] == 3'b111) && cur_bit);
      hist  <= {hist[3:0], cur_bit};
      if (fill != 3'd5) fill <= fill + 3'd1;
    end
  end
`else
  assign exp_z = 1'b0;
`endif

endmodule

// File: tb/tb_run_pattern_gen.sv
// tb/tb_run_pattern_gen.sv - self-checking bench for run_pattern_gen against a queue-based model
module tb_run_pattern_gen;
  localparam int LEN_W = 4;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_bit = 1'b0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             cmd_ready;
  logic             w;
  logic             w_valid;
  logic             busy;
  logic             done;
  logic             exp_z;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic b;
    int   len;
  } cmd_t;

  cmd_t cmd_q[$];
  logic hist_q[$];
  logic m_active;
  logic m_bit;
  logic m_w;
  logic m_wv;
  logic m_done;
  logic m_expz;
  int   m_left;

  run_pattern_gen #(.LEN_W(LEN_W), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_bit(cmd_bit),
    .cmd_len(cmd_len),
    .w(w),
    .w_valid(w_valid),
    .busy(busy),
    .done(done),
    .exp_z(exp_z)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b at t=%0t", tag, obs, expv, $time);
    end
  endtask

  function automatic logic m_ready();
    return cmd_q.size() < DEPTH;
  endfunction

  task automatic model_reset();
    cmd_q.delete();
    hist_q.delete();
    m_active = 1'b0;
    m_bit    = 1'b0;
    m_w      = 1'b0;
    m_wv     = 1'b0;
    m_done   = 1'b0;
    m_expz   = 1'b0;
    m_left   = 0;
  endtask

  task automatic model_load();
    cmd_t c;
    c = cmd_q.pop_front();
    m_bit  = c.b;
    m_left = c.len;
  endtask

  task automatic model_emit(input logic b);
`ifdef RUN_PATTERN_GEN_EXPECT_Z_EN
    int   n;
    logic zeros;
    logic ones;
`endif
    m_w  = b;
    m_wv = 1'b1;
`ifdef RUN_PATTERN_GEN_EXPECT_Z_EN
    n     = hist_q.size();
    zeros = (n >= 4);
    ones  = (n >= 3) && b;
    for (int k = 1; k <= 4; k++) if (k <= n && hist_q[n-k] !== 1'b0) zeros = 1'b0;
    for (int k = 1; k <= 3; k++) if (k <= n && hist_q[n-k] !== 1'b1) ones = 1'b0;
    m_expz = zeros | ones;
    hist_q.push_back(b);
    if (hist_q.size() > 5) void'(hist_q.pop_front());
`endif
  endtask

  task automatic model_step(input logic e, input logic pushed, input logic b, input logic [LEN_W-1:0] l);
    int pending;
    pending = cmd_q.size();
    m_wv    = 1'b0;
    m_done  = 1'b0;
    if (!m_active) begin
      if (pending > 0 && e) begin
        model_load();
        m_active = 1'b1;
      end
    end else if (e) begin
      model_emit(m_bit);
      m_left--;
      if (m_left == 0) begin
        if (pending > 0) begin
          model_load();
        end else begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end
    end
    if (pushed) cmd_q.push_back('{b, (l == '0) ? (1 << LEN_W) : int'(l)});
  endtask

  task automatic check_outputs();
    check("w", w, m_w);
    check("w_valid", w_valid, m_wv);
    check("done", done, m_done);
    check("busy", busy, m_active || (cmd_q.size() != 0));
    check("exp_z", exp_z, m_expz);
  endtask

  task automatic tick(input logic e, input logic v, input logic b, input logic [LEN_W-1:0] l, output logic acc);
    @(negedge clk);
    en        = e;
    cmd_valid = v;
    cmd_bit   = b;
    cmd_len   = l;
    #1;
    check("cmd_ready", cmd_ready, m_ready());
    acc = v && m_ready();
    @(posedge clk);
    model_step(e, acc, b, l);
    #1;
    check_outputs();
  endtask

  task automatic send(input logic e, input logic b, input logic [LEN_W-1:0] l);
    logic acc;
    acc = 1'b0;
    for (int g = 0; g < 40 && !acc; g++) tick(e, 1'b1, b, l, acc);
    checks++;
    assert (acc) else begin
      errors++;
      $error("FAIL send_timeout: observed accepted=%b expected=1 at t=%0t", acc, $time);
    end
  endtask

  task automatic idle(input int n, input logic e);
    logic acc;
    for (int i = 0; i < n; i++) tick(e, 1'b0, 1'b0, '0, acc);
  endtask

  initial begin
    logic acc;
    model_reset();
    #1;
    check_outputs();
    check("cmd_ready_reset", cmd_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // single run {1,3}
    send(1'b1, 1'b1, 4'd3);
    idle(6, 1'b1);

    // back-to-back runs {0,4},{1,2},{0,1}
    send(1'b1, 1'b0, 4'd4);
    send(1'b1, 1'b1, 4'd2);
    send(1'b1, 1'b0, 4'd1);
    idle(10, 1'b1);

    // fill the FIFO with the serializer frozen, fifth command held off
    for (int i = 0; i < 4; i++) send(1'b0, i[0], 4'(i + 1));
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1, 4'd2, acc);
    send(1'b1, 1'b1, 4'd2);
    idle(30, 1'b1);

    // len 0 encodes 16
    send(1'b1, 1'b1, 4'd0);
    idle(20, 1'b1);

    // enable dropped for two cycles mid-run
    send(1'b1, 1'b0, 4'd5);
    idle(3, 1'b1);
    idle(2, 1'b0);
    idle(6, 1'b1);

    // asynchronous reset mid-run with two commands queued
    send(1'b1, 1'b1, 4'd6);
    send(1'b1, 1'b0, 4'd3);
    send(1'b1, 1'b1, 4'd2);
    idle(2, 1'b1);
    @(negedge clk);
    en        = 1'b0;
    cmd_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    check("cmd_ready_async_reset", cmd_ready, 1'b1);
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
    idle(3, 1'b1);

    // detector expectation runs
    send(1'b1, 1'b0, 4'd5);
    idle(8, 1'b1);
    send(1'b1, 1'b1, 4'd4);
    idle(8, 1'b1);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      tick($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom), 4'($urandom), acc);
    end
    idle(100, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
